// File: rtl/cdr_phase_filter.sv
// CDR loop filter: integrates early/late votes from the phase detector, steps the
// sampling phase index when the vote magnitude reaches THRESH, and tracks lock.
module cdr_phase_filter #(
  parameter int ACC_W    = 5,
  parameter int THRESH   = 8,
  parameter int LOCK_CNT = 32,
  parameter int LOSS_CNT = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_T,
  input  logic       i_E,
  input  logic [5:0] i_nb_P,
  output logic       o_up,
  output logic       o_dn,
  output logic [5:0] o_phase,
  output logic       o_lock
);

  typedef enum logic {ACQ, LOCK} state_t;

  localparam logic signed [ACC_W-1:0] ZERO  = '0;
  localparam logic signed [ACC_W-1:0] ONE   = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] THR_P = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] THR_N = -THR_P;
  localparam logic [7:0]              LOCK_C = 8'(LOCK_CNT);
  localparam logic [7:0]              LOSS_C = 8'(LOSS_CNT);

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc, acc_nxt, vote;
  logic [7:0]               quiet, quiet_nxt, miss, miss_nxt;
  logic [5:0]               phase, phase_nxt;
  logic                     up_q, dn_q, step_up, step_dn, quiet_hit;

  // Saturating single-vote update; the clamp is a guard, the step rule keeps |acc| < THRESH.
  function automatic logic signed [ACC_W-1:0] vote_sum(input logic signed [ACC_W-1:0] a,
                                                       input logic early);
    if (early) return (a == THR_N) ? THR_N : a - ONE;
    else       return (a == THR_P) ? THR_P : a + ONE;
  endfunction

  function automatic logic [7:0] quiet_inc(input logic [7:0] q);
    return (q >= LOCK_C) ? LOCK_C : q + 8'd1;
  endfunction

  // Modular phase index; an out-of-range index (modulus shrink) snaps back to 0.
  function automatic logic [5:0] next_phase(input logic [5:0] p, input logic [5:0] n,
                                            input logic up, input logic dn);
    if (n < 6'd2)  return 6'd0;
    if (p >= n)    return 6'd0;
    if (up)        return (p == n - 6'd1) ? 6'd0 : p + 6'd1;
    if (dn)        return (p == 6'd0) ? n - 6'd1 : p - 6'd1;
    return p;
  endfunction

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    quiet_nxt = quiet;
    miss_nxt  = miss;
    vote      = acc;
    step_up   = 1'b0;
    step_dn   = 1'b0;
    quiet_hit = 1'b0;

    if (i_en && i_T) begin
      vote = vote_sum(acc, i_E);
      if (vote == THR_P) begin
        step_up = 1'b1;
        acc_nxt = ZERO;
      end else if (vote == THR_N) begin
        step_dn = 1'b1;
        acc_nxt = ZERO;
      end else begin
        acc_nxt = vote;
      end
    end else if (i_en) begin
      quiet_nxt = quiet_inc(quiet);
      quiet_hit = (quiet_nxt == LOCK_C);
    end

    if (step_up || step_dn) quiet_nxt = 8'd0;

    phase_nxt = next_phase(phase, i_nb_P, step_up, step_dn);

    case (state)
      ACQ: begin
        miss_nxt = 8'd0;
        if (quiet_hit) begin
          state_nxt = LOCK;
          quiet_nxt = 8'd0;
        end
      end
      LOCK: begin
        if (step_up || step_dn) begin
          if (miss + 8'd1 == LOSS_C) begin
            state_nxt = ACQ;
            miss_nxt  = 8'd0;
          end else begin
            miss_nxt = miss + 8'd1;
          end
        end else if (quiet_hit) begin
          miss_nxt  = 8'd0;
          quiet_nxt = 8'd0;
        end
      end
      default: state_nxt = ACQ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= ACQ;
      acc   <= ZERO;
      quiet <= 8'd0;
      miss  <= 8'd0;
      phase <= 6'd0;
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      quiet <= quiet_nxt;
      miss  <= miss_nxt;
      phase <= phase_nxt;
      up_q  <= step_up;
      dn_q  <= step_dn;
    end
  end

  assign o_up    = up_q;
  assign o_dn    = dn_q;
  assign o_phase = phase;
  assign o_lock  = (state == LOCK);

endmodule

// File: tb/tb_cdr_phase_filter.sv
// Self-checking bench for cdr_phase_filter: vector table plus hand-built corner sequences.
module tb_cdr_phase_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       t_in = 1'b0;
  logic       e_in = 1'b0;
  logic [5:0] nb_p = 6'd20;
  logic       up, dn, lock;
  logic [5:0] phase;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       up;
    logic       dn;
    logic [5:0] ph;
    logic       lk;
  } exp_t;

  typedef struct {
    logic       t;
    logic       e;
    logic       xu;
    logic       xd;
    logic [5:0] xp;
    logic       xl;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[19];

  cdr_phase_filter dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (en),
    .i_T    (t_in),
    .i_E    (e_in),
    .i_nb_P (nb_p),
    .o_up   (up),
    .o_dn   (dn),
    .o_phase(phase),
    .o_lock (lock)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_pop(input string name);
    exp_t x;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    x = sbq.pop_front();
    chk({name, ".up"},    int'(up),    int'(x.up));
    chk({name, ".dn"},    int'(dn),    int'(x.dn));
    chk({name, ".phase"}, int'(phase), int'(x.ph));
    chk({name, ".lock"},  int'(lock),  int'(x.lk));
  endtask

  task automatic strobe(input logic t, input logic e, input logic xu, input logic xd,
                        input logic [5:0] xp, input logic xl, input int gap);
    exp_t x;
    @(negedge clk);
    en = 1'b1; t_in = t; e_in = e;
    x.up = xu; x.dn = xd; x.ph = xp; x.lk = xl;
    sbq.push_back(x);
    @(posedge clk); #1;
    en = 1'b0; t_in = 1'b0; e_in = 1'b0;
    check_pop("strobe");
    @(posedge clk); #1;
    chk("pulse_width.up", int'(up), 0);
    chk("pulse_width.dn", int'(dn), 0);
    repeat (gap - 1) @(posedge clk);
  endtask

  // Seven non-stepping votes followed by the stepping one.
  task automatic step_run(input logic early, input logic [5:0] ph_before, input logic [5:0] ph_after,
                          input logic lk_mid, input logic lk_end);
    for (int i = 0; i < 7; i++) strobe(1'b1, early, 1'b0, 1'b0, ph_before, lk_mid, 2);
    strobe(1'b1, early, !early, early, ph_after, lk_end, 2);
  endtask

  task automatic do_reset(input int n);
    exp_t x;
    @(negedge clk);
    rst = 1'b0; en = 1'b0; t_in = 1'b0; e_in = 1'b0;
    x.up = 1'b0; x.dn = 1'b0; x.ph = 6'd0; x.lk = 1'b0;
    sbq.push_back(x);
    repeat (n) @(posedge clk);
    #1;
    check_pop("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    exp_t x;
    for (int i = 0; i < 7; i++)  tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 1'b0};
    for (int i = 8; i < 15; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd1, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd1, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd1, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd2, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd2, 1'b0};

    // Reset, then idle with the strobe low
    nb_p = 6'd20;
    do_reset(3);
    repeat (10) @(posedge clk);
    #1;
    chk("idle.up", int'(up), 0);
    chk("idle.dn", int'(dn), 0);
    chk("idle.phase", int'(phase), 0);
    chk("idle.lock", int'(lock), 0);

    // Table: 8 late -> up; 7 late + 1 early -> no step; 2 more late -> step
    for (int i = 0; i < 19; i++)
      strobe(tbl[i].t, tbl[i].e, tbl[i].xu, tbl[i].xd, tbl[i].xp, tbl[i].xl, 25);

    // Wrap in both directions at modulus 20
    do_reset(1);
    step_run(1'b1, 6'd0, 6'd19, 1'b0, 1'b0);
    step_run(1'b0, 6'd19, 6'd0, 1'b0, 1'b0);
    step_run(1'b1, 6'd0, 6'd19, 1'b0, 1'b0);

    // Lock acquisition, miss clear by a quiet run, loss after three steps
    do_reset(1);
    for (int k = 1; k <= 32; k++) strobe(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, k == 32, 2);
    step_run(1'b0, 6'd0, 6'd1, 1'b1, 1'b1);
    for (int k = 1; k <= 32; k++) strobe(1'b0, 1'b0, 1'b0, 1'b0, 6'd1, 1'b1, 2);
    step_run(1'b0, 6'd1, 6'd2, 1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) strobe(1'b0, 1'b0, 1'b0, 1'b0, 6'd2, 1'b1, 2);
    step_run(1'b0, 6'd2, 6'd3, 1'b1, 1'b1);
    step_run(1'b0, 6'd3, 6'd4, 1'b1, 1'b0);

    // Mid-operation reset discards votes
    do_reset(1);
    for (int k = 0; k < 5; k++) strobe(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 2);
    do_reset(1);
    for (int k = 0; k < 3; k++) strobe(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 2);
    for (int k = 0; k < 4; k++) strobe(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 2);
    strobe(1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 1'b0, 2);
    for (int k = 0; k < 7; k++) strobe(1'b1, 1'b0, 1'b0, 1'b0, 6'd1, 1'b0, 2);
    // Reset coinciding with what would be the stepping strobe: no pulse
    @(negedge clk);
    rst = 1'b0; en = 1'b1; t_in = 1'b1; e_in = 1'b0;
    x.up = 1'b0; x.dn = 1'b0; x.ph = 6'd0; x.lk = 1'b0;
    sbq.push_back(x);
    @(posedge clk); #1;
    en = 1'b0; t_in = 1'b0;
    check_pop("reset_on_step");
    @(negedge clk);
    rst = 1'b1;
    step_run(1'b0, 6'd0, 6'd1, 1'b0, 1'b0);

    // Walk down to phase 15, then shrink the modulus
    do_reset(1);
    for (int k = 1; k <= 40; k++)
      strobe(1'b1, 1'b1, 1'b0, (k % 8) == 0, (k < 8) ? 6'd0 : 6'(20 - k / 8), 1'b0, 2);
    @(negedge clk);
    nb_p = 6'd10;
    x.up = 1'b0; x.dn = 1'b0; x.ph = 6'd0; x.lk = 1'b0;
    sbq.push_back(x);
    @(posedge clk); #1;
    check_pop("shrink");
    @(negedge clk);
    nb_p = 6'd1;
    step_run(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    step_run(1'b1, 6'd0, 6'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdr_phase_filter.md
Name: cdr_phase_filter

Overview:
- Downstream stage of the CDR phase detector.
- Consumes the registered transition (T) and early (E) flags, one sample per detector enable strobe.
- Integrates early/late votes in a saturating up/down accumulator and issues single-cycle phase step commands.
- Maintains the selected sampling phase index modulo the runtime phase count, and reports lock status to the demodulator control.

Parameters:
- ACC_W, 5: accumulator width in bits, signed two's complement.
- THRESH, 8: vote magnitude that triggers a phase step; must be < 2^(ACC_W-1).
- LOCK_CNT, 32: consecutive quiet strobes needed to declare lock or to clear the miss count; counter is 8 bits, value ≤ 255.
- LOSS_CNT, 3: phase steps taken while locked, without an intervening clear, that drop lock.

Ports:
- i_clk  in  1  work clock, 50 MHz.
- i_rst  in  1  synchronous, active-low reset.
- i_en  in  1  one-cycle strobe; i_T/i_E valid.
- i_T  in  1  transition flag from the phase detector.
- i_E  in  1  early flag from the phase detector.
- i_nb_P  in  6  number of available phases (modulus).
- o_up  out  1  one-cycle pulse: phase index incremented.
- o_dn  out  1  one-cycle pulse: phase index decremented.
- o_phase  out  6  current sampling phase index.
- o_lock  out  1  loop locked.

Behaviour:
- Reset (i_rst=0 at a clock edge) values:
  - o_up=0, o_dn=0, o_phase=0, o_lock=0.
  - Accumulator=0, quiet counter=0, miss counter=0, state=ACQ.
  - Reset takes priority over all other inputs. Reset mid-operation discards accumulated votes; no pulse is emitted in the reset cycle.
- Voting. Evaluated only when i_en=1; when i_en=0, all state holds and o_up/o_dn are 0.
  - i_T=0: no vote; accumulator unchanged; counts as a quiet strobe.
  - i_T=1, i_E=0 (late): accumulator +1.
  - i_T=1, i_E=1 (early): accumulator −1.
- Step rule, computed at the edge following the strobe (latency 1 cycle):
  - Accumulator next value = +THRESH: accumulator←0, o_up=1 for 1 cycle, o_phase←o_phase+1. Wrap: o_phase=i_nb_P−1 goes to 0.
  - Accumulator next value = −THRESH: accumulator←0, o_dn=1 for 1 cycle, o_phase←o_phase−1. Wrap: o_phase=0 goes to i_nb_P−1.
  - o_up and o_dn are never both 1.
  - A stepping strobe is not a quiet strobe.
  - A vote strobe that does not step is also not quiet, and leaves the quiet counter unchanged.
- Accumulator saturation: never exceeds ±THRESH by construction. No overflow is possible for the legal ACC_W/THRESH combination.
- Phase modulus:
  - i_nb_P < 2: o_phase is forced to 0 and step pulses are still emitted.
  - If i_nb_P changes so that o_phase ≥ i_nb_P, o_phase←0 on the next clock, regardless of i_en.
- Quiet counter: increments on each quiet strobe, saturating at LOCK_CNT; cleared on every step.
- FSM, two states:
  - ACQ: o_lock=0; miss counter held at 0. When the quiet counter reaches LOCK_CNT, go to LOCK and clear the quiet counter. o_lock rises on the same edge the state changes.
  - LOCK: o_lock=1.
    - Each step increments the miss counter.
    - Quiet counter reaching LOCK_CNT clears the miss counter and the quiet counter.
    - Miss counter reaching LOSS_CNT: go to ACQ, clear the miss counter, o_lock=0 on that edge.
  - Simultaneous events in LOCK: a step and the quiet counter reaching LOCK_CNT cannot coincide, because a step clears the quiet counter. The step wins.

Test Plan:
- Reset with i_nb_P=20: hold i_rst=0 for 3 cycles → o_phase=0, o_lock=0, o_up=o_dn=0; release with i_en=0 for 10 cycles → all outputs unchanged.
- 8 late strobes (T=1, E=0), i_en spaced 25 cycles apart → o_up pulses exactly 1 cycle after the 8th strobe, o_phase=1, accumulator back to 0. Seven late strobes then one early strobe → no pulse.
- Wrap: i_nb_P=20, o_phase=19, 8 late strobes → o_phase=0. Then 8 early strobes → o_dn pulse, o_phase=19.
- Lock: 32 strobes with T=0 → o_lock=1 one cycle after the 32nd strobe. Then 3 steps of 8 late strobes each, with no 32-quiet run between them → o_lock=0 after the 3rd o_up.
- Reset mid-operation: 5 late strobes, assert i_rst=0 for 1 cycle, then 3 late strobes → no o_up. After 5 more late strobes (8 total since reset), o_up fires.
- Modulus shrink: o_phase=15, drive i_nb_P=10 → o_phase=0 next clock. i_nb_P=1 with 8 late strobes → o_up pulses, o_phase stays 0.
